// File: rtl/single_min_bist.sv
// Stimulus/capture driver for the single-precision min unit.
// Issues directed then LFSR pairs, predicts min(a,b), checks dut_z.
module single_min_bist #(
  parameter int          LATENCY     = 1,
  parameter int          NUM_VECTORS = 1000,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] dut_a,
  output logic [31:0] dut_b,
  input  logic [31:0] dut_z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] error_count,
  output logic [15:0] vector_count,
  output logic [15:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  function automatic logic [31:0] step(input logic [31:0] s);
    step = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Monotone integer key: orders floats with -0 below +0
  function automatic logic [31:0] key(input logic [31:0] x);
    key = x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  function automatic logic [63:0] dir_pair(input logic [2:0] i);
    unique case (i)
      3'd0: dir_pair = {32'h0000_0000, 32'h8000_0000};
      3'd1: dir_pair = {32'h8000_0000, 32'h0000_0000};
      3'd2: dir_pair = {32'h3F80_0000, 32'h4000_0000};
      3'd3: dir_pair = {32'hBF80_0000, 32'h3F80_0000};
      3'd4: dir_pair = {32'h7F80_0000, 32'h3F80_0000};
      3'd5: dir_pair = {32'hFF80_0000, 32'hFF7F_FFFF};
      3'd6: dir_pair = {32'h4049_0FDB, 32'h4049_0FDB};
      default: dir_pair = {32'h0000_0001, 32'h0000_0002};
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] lfsr_q;
  logic [15:0] idx_q;
  logic [3:0]  drain_q;
  logic [15:0] err_q, vec_q, ff_q;

  logic        vld_p  [LATENCY+1];
  logic        skip_p [LATENCY+1];
  logic [31:0] exp_p  [LATENCY+1];
  logic [15:0] idx_p  [LATENCY+1];

  logic        issue, last_issue, start_run, rnd;
  logic [31:0] pa, pb, exp_v;
  logic [63:0] dp;
  logic        skip_v, chk, bad;

  always_comb begin
    dp     = dir_pair(idx_q[2:0]);
    rnd    = idx_q >= 16'd8;
    pa     = rnd ? lfsr_q : dp[63:32];
    pb     = rnd ? step(lfsr_q) : dp[31:0];
    skip_v = is_nan(pa) || is_nan(pb);
    exp_v  = (key(pa) <= key(pb)) ? pa : pb;
  end

  assign issue      = state_q == RUN;
  assign last_issue = issue && (idx_q == LAST);
  assign start_run  = start && (state_q == IDLE || state_q == DONE);
  assign chk        = vld_p[LATENCY] && busy;
  assign bad        = !skip_p[LATENCY] && (dut_z != exp_p[LATENCY]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (drain_q == LAT4) state_d = DONE;
      default: if (start) state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      idx_q   <= '0;
      drain_q <= '0;
      dut_a   <= '0;
      dut_b   <= '0;
      err_q   <= '0;
      vec_q   <= '0;
      ff_q    <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      if (start_run) begin
        lfsr_q  <= SEED;
        idx_q   <= '0;
        drain_q <= '0;
        err_q   <= '0;
        vec_q   <= '0;
        ff_q    <= 16'hFFFF;
      end else begin
        if (issue) begin
          dut_a <= pa;
          dut_b <= pb;
          idx_q <= idx_q + 16'd1;
          if (rnd) lfsr_q <= step(step(lfsr_q));
        end
        if (state_q == DRAIN) drain_q <= drain_q + 4'd1;
        if (chk) begin
          vec_q <= vec_q + 16'd1;
          if (bad) begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            if (ff_q == 16'hFFFF) ff_q <= idx_p[LATENCY];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= issue && !start_run;
      for (int i = 1; i <= LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Payload needs no reset; only the valid bits gate checking
  always_ff @(posedge clk) begin
    exp_p[0]  <= exp_v;
    skip_p[0] <= skip_v;
    idx_p[0]  <= idx_q;
    for (int i = 1; i <= LATENCY; i++) begin
      exp_p[i]  <= exp_p[i-1];
      skip_p[i] <= skip_p[i-1];
      idx_p[i]  <= idx_p[i-1];
    end
  end

  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign done         = state_q == DONE;
  assign pass         = done && (err_q == 16'd0);
  assign error_count  = err_q;
  assign vector_count = vec_q;
  assign first_fail   = ff_q;

endmodule
